alu_arbiter: RTL

Shares the single combinational 32-bit ALU between two requesters (lane 0, lane 1) using a req/gnt handshake on the input side and a valid/ready handshake on the result side. Each accepted operation is captured into an operand register, driven to the ALU for one cycle, and its result (plus zero flag and requester id) is held in a result register until the consumer takes it. It sits between the issue logic and the ALU instance, and owns all ALU `funct`/operand inputs.

---
 rtl/alu_arbiter_if.sv | 31 +++
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Request/grant and result handshake bundle between the issue logic and alu_arbiter.
// master = requesters plus result consumer; slave = the arbiter.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0;
  logic             req1;
  logic [3:0]       funct0;
  logic [3:0]       funct1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             res_id;

  modport master (
    output req0, req1, funct0, funct1, a0, b0, a1, b1, res_ready,
    input  gnt0, gnt1, res_valid, res_data, res_zero, res_id
  );

  modport slave (
    input  req0, req1, funct0, funct1, a0, b0, a1, b1, res_ready,
    output gnt0, gnt1, res_valid, res_data, res_zero, res_id
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: IDLE -> EXEC -> HOLD per operation.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; otherwise lane 0 has fixed priority.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  alu_arbiter_if.slave     bus,
  output logic [3:0]       alu_funct,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_funct_q, op_funct_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_id_q, op_id_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic             res_id_q, res_id_d;
  logic             pick1;
  logic             grant;

`ifdef ALU_ARB_RR_EN
  logic last_q, last_d;

  // last_q = lane granted most recently; the other lane wins a tie.
  assign pick1 = bus.req1 & (~bus.req0 | ~last_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant) begin
      last_d = pick1;
    end
  end
`else
  assign pick1 = bus.req1 & ~bus.req0;
`endif

  always_comb begin
    bus.gnt0 = (state_q == StIdle) & bus.req0 & ~pick1;
    bus.gnt1 = (state_q == StIdle) & pick1;
    grant    = bus.gnt0 | bus.gnt1;
  end

  always_comb begin
    state_d     = state_q;
    op_funct_d  = op_funct_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_id_d     = op_id_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_id_d    = res_id_q;
    case (state_q)
      StIdle: begin
        if (grant) begin
          op_funct_d = pick1 ? bus.funct1 : bus.funct0;
          op_a_d     = pick1 ? bus.a1 : bus.a0;
          op_b_d     = pick1 ? bus.b1 : bus.b0;
          op_id_d    = pick1;
          state_d    = StExec;
        end
      end
      StExec: begin
        res_data_d  = alu_out;
        res_zero_d  = alu_zero;
        res_id_d    = op_id_q;
        res_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      op_funct_q  <= 4'b0000;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_funct_q  <= op_funct_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_id_q     <= op_id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_id_q    <= res_id_d;
    end
  end

  // The ALU sees only zeros outside EXEC so its idle output is never meaningful.
  always_comb begin
    alu_funct = 4'b0000;
    alu_data1 = '0;
    alu_data2 = '0;
    if (state_q == StExec) begin
      alu_funct = op_funct_q;
      alu_data1 = op_a_q;
      alu_data2 = op_b_q;
    end
  end

  assign busy          = (state_q != StIdle);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.res_id    = res_id_q;

endmodule
